// File: rtl/playfield_store.sv
// playfield_store
//   Settled-cell storage for a COLS x ROWS Tetris playfield plus a 4-digit
//   BCD score. On a lock pulse the piece cells are written, full rows are
//   found bottom-up and collapsed one per SHIFT cycle, and the score is
//   updated. The renderer reads cells combinationally through rd_x/rd_y.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   lock, piece_type      settle request (sampled in IDLE) and its type 1..7
//   x1..x4, y1..y4        column/row of each of the four piece cells
//   clear                 wipe board, score, last_lines, game_over (IDLE only)
//   rd_x, rd_y, rd_type   renderer read port; 0 when out of range or empty
//   score_bcd             thousands in [15:12] down to units in [3:0]
//   busy                  sequence in progress (not IDLE)
//   done                  one-cycle pulse after the SCORE update
//   last_lines            rows cleared by the most recent lock
//   game_over             sticky: a lock landed on an occupied cell
module playfield_store #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lock,
  input  logic [2:0]  piece_type,
  input  logic [3:0]  x1,
  input  logic [3:0]  x2,
  input  logic [3:0]  x3,
  input  logic [3:0]  x4,
  input  logic [4:0]  y1,
  input  logic [4:0]  y2,
  input  logic [4:0]  y3,
  input  logic [4:0]  y4,
  input  logic        clear,
  input  logic [3:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic [2:0]  rd_type,
  output logic [15:0] score_bcd,
  output logic        busy,
  output logic        done,
  output logic [2:0]  last_lines,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_SCAN, S_SHIFT, S_SCORE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cells_q [ROWS][COLS];
  logic [2:0]  cells_d [ROWS][COLS];
  logic [3:0]  cx_q [4];
  logic [3:0]  cx_d [4];
  logic [4:0]  cy_q [4];
  logic [4:0]  cy_d [4];
  logic [2:0]  ptype_q, ptype_d;
  logic [4:0]  row_q, row_d;
  logic [2:0]  lines_q, lines_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  last_lines_q, last_lines_d;
  logic        done_q, done_d;
  logic        game_over_q, game_over_d;
  logic        row_full;

  function automatic logic [3:0] line_points(input logic [2:0] n);
    case (n)
      3'd0:    return 4'd0;
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  // Digit-wise BCD add of a small value; a carry out of the thousands
  // digit pins the result at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] s,
                                              input logic [3:0]  p);
    logic [15:0] r;
    logic [4:0]  d;
    logic [3:0]  cin;
    r   = 16'h0000;
    cin = p;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, s[4*i +: 4]} + {1'b0, cin};
      if (d > 5'd9) begin
        d   = d - 5'd10;
        cin = 4'd1;
      end else begin
        cin = 4'd0;
      end
      r[4*i +: 4] = d[3:0];
    end
    if (cin != 4'd0) r = 16'h9999;
    return r;
  endfunction

  // Row r is full when none of its cells is empty.
  always_comb begin
    row_full = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_q == 5'(r) && cells_q[r][c] == 3'd0) row_full = 1'b0;
  end

  // Out-of-range coordinates match no cell, so they read as empty.
  always_comb begin
    rd_type = 3'd0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (rd_y == 5'(r) && rd_x == 4'(c)) rd_type = cells_q[r][c];
  end

  always_comb begin
    state_d      = state_q;
    cells_d      = cells_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    ptype_d      = ptype_q;
    row_d        = row_q;
    lines_d      = lines_q;
    score_d      = score_q;
    last_lines_d = last_lines_q;
    done_d       = 1'b0;
    game_over_d  = game_over_q;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          cells_d      = '{default: '0};
          score_d      = 16'h0000;
          last_lines_d = 3'd0;
          game_over_d  = 1'b0;
        end else if (lock && !game_over_q) begin
          ptype_d = piece_type;
          cx_d[0] = x1;  cy_d[0] = y1;
          cx_d[1] = x2;  cy_d[1] = y2;
          cx_d[2] = x3;  cy_d[2] = y3;
          cx_d[3] = x4;  cy_d[3] = y4;
          lines_d = 3'd0;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // Overlap is judged against the board before this piece, so a piece
        // listing the same cell twice does not flag itself.
        for (int i = 0; i < 4; i++)
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              if (cy_q[i] == 5'(r) && cx_q[i] == 4'(c)) begin
                if (cells_q[r][c] != 3'd0) game_over_d = 1'b1;
                cells_d[r][c] = ptype_q;
              end
        row_d   = 5'(ROWS - 1);
        state_d = S_SCAN;
      end

      S_SCAN: begin
        if (row_full) begin
          lines_d = (lines_q == 3'd7) ? lines_q : lines_q + 3'd1;
          state_d = S_SHIFT;
        end else if (row_q == 5'd0) begin
          state_d = S_SCORE;
        end else begin
          row_d = row_q - 5'd1;
        end
      end

      S_SHIFT: begin
        // Everything above the full row drops by one; the same row is then
        // rescanned because new content has fallen into it.
        for (int r = 1; r < ROWS; r++)
          if (5'(r) <= row_q)
            for (int c = 0; c < COLS; c++) cells_d[r][c] = cells_q[r-1][c];
        for (int c = 0; c < COLS; c++) cells_d[0][c] = 3'd0;
        state_d = S_SCAN;
      end

      S_SCORE: begin
        score_d      = bcd_add_sat(score_q, line_points(lines_q));
        last_lines_d = lines_q;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cells_q      <= '{default: '0};
      cx_q         <= '{default: '0};
      cy_q         <= '{default: '0};
      ptype_q      <= 3'd0;
      row_q        <= 5'd0;
      lines_q      <= 3'd0;
      score_q      <= 16'h0000;
      last_lines_q <= 3'd0;
      done_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cells_q      <= cells_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      ptype_q      <= ptype_d;
      row_q        <= row_d;
      lines_q      <= lines_d;
      score_q      <= score_d;
      last_lines_q <= last_lines_d;
      done_q       <= done_d;
      game_over_q  <= game_over_d;
    end
  end

  assign score_bcd  = score_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign last_lines = last_lines_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_playfield_store.sv
module tb_playfield_store;
  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int SCOLS = 2;
  localparam int SROWS = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  // main instance
  logic        lock = 1'b0, clear = 1'b0;
  logic [2:0]  piece_type = 3'd0;
  logic [3:0]  x1 = 4'd0, x2 = 4'd0, x3 = 4'd0, x4 = 4'd0;
  logic [4:0]  y1 = 5'd0, y2 = 5'd0, y3 = 5'd0, y4 = 5'd0;
  logic [3:0]  rd_x = 4'd0;
  logic [4:0]  rd_y = 5'd0;
  logic [2:0]  rd_type, last_lines;
  logic [15:0] score_bcd;
  logic        busy, done, game_over;

  // small instance, used to reach the score ceiling in few cycles
  logic        s_lock = 1'b0, s_clear = 1'b0;
  logic [2:0]  s_type = 3'd0;
  logic [3:0]  s_x1 = 4'd0, s_x2 = 4'd0, s_x3 = 4'd0, s_x4 = 4'd0;
  logic [4:0]  s_y1 = 5'd0, s_y2 = 5'd0, s_y3 = 5'd0, s_y4 = 5'd0;
  logic [3:0]  s_rd_x = 4'd0;
  logic [4:0]  s_rd_y = 5'd0;
  logic [2:0]  s_rd_type, s_last;
  logic [15:0] s_score;
  logic        s_busy, s_done, s_go;

  playfield_store #(.COLS(COLS), .ROWS(ROWS)) u_dut (
    .clk(clk), .resetn(resetn), .lock(lock), .piece_type(piece_type),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .clear(clear), .rd_x(rd_x), .rd_y(rd_y), .rd_type(rd_type),
    .score_bcd(score_bcd), .busy(busy), .done(done),
    .last_lines(last_lines), .game_over(game_over));

  playfield_store #(.COLS(SCOLS), .ROWS(SROWS)) u_small (
    .clk(clk), .resetn(resetn), .lock(s_lock), .piece_type(s_type),
    .x1(s_x1), .x2(s_x2), .x3(s_x3), .x4(s_x4),
    .y1(s_y1), .y2(s_y2), .y3(s_y3), .y4(s_y4),
    .clear(s_clear), .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_type(s_rd_type),
    .score_bcd(s_score), .busy(s_busy), .done(s_done),
    .last_lines(s_last), .game_over(s_go));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int     lines;
    int     score;
    bit     go;
    longint cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t sexp_q[$];

  // reference model state
  int mb[ROWS][COLS];
  int mscore = 0;
  bit mgo = 1'b0;
  int sscore = 0;

  int sdx[7][4] = '{'{0,1,2,3}, '{0,1,0,1}, '{0,1,2,1}, '{1,2,0,1},
                    '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
  int sdy[7][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,1,1},
                    '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int pts(input int n);
    case (n)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 9999) ? 9999 : a + b;
  endfunction

  // monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (resetn && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("last_lines", last_lines, e.lines);
        chk("score", score_bcd, to_bcd(e.score));
        chk("game_over", game_over, e.go);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", busy, 0);
      end
    end
    if (resetn && s_done) begin
      if (sexp_q.size() == 0) chk("small_unexpected_done", 1, 0);
      else begin
        e = sexp_q.pop_front();
        chk("small_last_lines", s_last, e.lines);
        chk("small_score", s_score, to_bcd(e.score));
        chk("small_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Place the piece, then drop full rows by compacting the survivors.
  task automatic model_apply(input int t, input int xs[4], input int ys[4],
                             output int n);
    int  nb[ROWS][COLS];
    int  dst;
    bit  full;
    for (int k = 0; k < 4; k++)
      if (xs[k] < COLS && ys[k] < ROWS && mb[ys[k]][xs[k]] != 0) mgo = 1'b1;
    for (int k = 0; k < 4; k++)
      if (xs[k] < COLS && ys[k] < ROWS) mb[ys[k]][xs[k]] = t;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) nb[r][c] = 0;
    dst = ROWS - 1;
    n   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (mb[r][c] == 0) full = 1'b0;
      if (full) n++;
      else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = mb[r][c];
        dst--;
      end
    end
    mb     = nb;
    mscore = sat_add(mscore, pts(n));
  endtask

  task automatic model_wipe();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    mscore = 0;
    mgo    = 1'b0;
  endtask

  task automatic drive(input int t, input int xs[4], input int ys[4]);
    piece_type = 3'(t);
    x1 = 4'(xs[0]); x2 = 4'(xs[1]); x3 = 4'(xs[2]); x4 = 4'(xs[3]);
    y1 = 5'(ys[0]); y2 = 5'(ys[1]); y3 = 5'(ys[2]); y4 = 5'(ys[3]);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic do_lock(input int t, input int xs[4], input int ys[4]);
    int n;
    bit acc;
    n   = 0;
    acc = !mgo;
    if (acc) model_apply(t, xs, ys, n);
    drive(t, xs, ys);
    lock = 1'b1;
    @(posedge clk);
    #1 lock = 1'b0;
    if (acc) exp_q.push_back(exp_t'{n, mscore, mgo, cyc + ROWS + 2 + 2 * n});
    wait_drain();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_wipe();
  endtask

  task automatic sweep(input string name);
    int bad;
    bad = 0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        rd_x = 4'(x);
        rd_y = 5'(y);
        #1;
        if (rd_type !== 3'(mb[y][x])) bad++;
      end
    rd_x = 4'd12; rd_y = 5'd3;  #1; if (rd_type !== 3'd0) bad++;
    rd_x = 4'd2;  rd_y = 5'd25; #1; if (rd_type !== 3'd0) bad++;
    chk(name, bad, 0);
  endtask

  task automatic s_do(input int t, input int xs[4], input int ys[4], input int n);
    s_type = 3'(t);
    s_x1 = 4'(xs[0]); s_x2 = 4'(xs[1]); s_x3 = 4'(xs[2]); s_x4 = 4'(xs[3]);
    s_y1 = 5'(ys[0]); s_y2 = 5'(ys[1]); s_y3 = 5'(ys[2]); s_y4 = 5'(ys[3]);
    s_lock = 1'b1;
    @(posedge clk);
    #1 s_lock = 1'b0;
    sscore = sat_add(sscore, pts(n));
    sexp_q.push_back(exp_t'{n, sscore, 1'b0, cyc + SROWS + 2 + 2 * n});
    for (int i = 0; i < 40 && sexp_q.size() != 0; i++) @(negedge clk);
    if (sexp_q.size() != 0) begin
      chk("small_done_timeout", 0, 1);
      sexp_q.delete();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int xs[4], ys[4], ax[4], ay[4], bx[4], by[4];
    int s, w, x0, best;
    bit ok;
    model_wipe();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // reset state
    rd_x = 4'd3; rd_y = 5'd7; #1;
    chk("reset_rd_type", rd_type, 0);
    chk("reset_score", score_bcd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_last_lines", last_lines, 0);

    // O piece resting on the floor
    xs = '{4, 5, 4, 5}; ys = '{18, 18, 19, 19};
    do_lock(2, xs, ys);
    sweep("board_o_piece");

    // single-row clear with content dropping from row 18
    do_clear();
    sweep("board_after_clear");
    xs = '{0, 1, 2, 3}; ys = '{19, 19, 19, 19}; do_lock(1, xs, ys);
    xs = '{4, 5, 8, 9}; ys = '{19, 19, 19, 19}; do_lock(3, xs, ys);
    xs = '{6, 7, 6, 7}; ys = '{19, 19, 18, 18}; do_lock(5, xs, ys);
    sweep("board_one_line");

    // four-row clear with a vertical I
    do_clear();
    for (int k = 0; k < 9; k++) begin
      xs = '{k, k, k, k}; ys = '{16, 17, 18, 19};
      do_lock(k % 7 + 1, xs, ys);
    end
    xs = '{9, 9, 9, 9}; ys = '{16, 17, 18, 19};
    do_lock(7, xs, ys);
    sweep("board_four_lines");

    // reset while the board is collapsing a full row
    xs = '{0, 1, 2, 3}; ys = '{19, 19, 19, 19}; do_lock(1, xs, ys);
    xs = '{4, 5, 6, 7}; ys = '{19, 19, 19, 19}; do_lock(2, xs, ys);
    xs = '{8, 8, 8, 8}; ys = '{19, 18, 17, 16}; do_lock(3, xs, ys);
    xs = '{9, 9, 9, 9}; ys = '{19, 18, 17, 16};
    drive(6, xs, ys);
    lock = 1'b1;
    @(posedge clk);
    #1 lock = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rd_x = 4'd9; rd_y = 5'd18;
    #1;
    chk("mid_seq_busy", busy, 1);
    chk("mid_seq_partial_cell", rd_type, 6);
    resetn = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_score", score_bcd, 0);
    chk("async_rst_last_lines", last_lines, 0);
    chk("async_rst_game_over", game_over, 0);
    chk("async_rst_cell", rd_type, 0);
    model_wipe();
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (40) @(negedge clk);
    sweep("board_after_reset");

    // random hard drops, occasionally with one cell out of range
    for (int p = 0; p < 40; p++) begin
      s  = $urandom_range(0, 6);
      w  = 0;
      for (int k = 0; k < 4; k++) if (sdx[s][k] + 1 > w) w = sdx[s][k] + 1;
      x0 = $urandom_range(0, COLS - w);
      best = -1;
      for (int y0 = 0; y0 < ROWS; y0++) begin
        ok = 1'b1;
        for (int k = 0; k < 4; k++)
          if (y0 + sdy[s][k] >= ROWS || mb[y0 + sdy[s][k]][x0 + sdx[s][k]] != 0)
            ok = 1'b0;
        if (!ok) break;
        best = y0;
      end
      if (best < 0) begin
        do_clear();
      end else begin
        for (int k = 0; k < 4; k++) begin
          xs[k] = x0 + sdx[s][k];
          ys[k] = best + sdy[s][k];
        end
        if ($urandom_range(0, 7) == 0) xs[3] = 10 + $urandom_range(0, 5);
        do_lock(s + 1, xs, ys);
        sweep("board_random");
      end
    end

    // overlap sets game_over; the next lock is ignored
    do_clear();
    xs = '{0, 1, 0, 1}; ys = '{18, 18, 19, 19}; do_lock(2, xs, ys);
    xs = '{1, 2, 1, 2}; ys = '{19, 19, 18, 18}; do_lock(4, xs, ys);
    chk("game_over_flag", game_over, 1);
    xs = '{5, 6, 7, 8}; ys = '{10, 10, 10, 10}; do_lock(1, xs, ys);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ignored_lock_busy", busy, 0);
    end
    sweep("board_after_ignored_lock");

    // clear wins over a simultaneous lock
    do_clear();
    chk("clear_game_over", game_over, 0);
    xs = '{3, 4, 5, 4}; ys = '{10, 10, 10, 11}; do_lock(3, xs, ys);
    xs = '{0, 1, 2, 3}; ys = '{0, 0, 0, 0};
    drive(1, xs, ys);
    lock = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1 lock = 1'b0; clear = 1'b0;
    model_wipe();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clear_lock_busy", busy, 0);
    end
    chk("clear_lock_score", score_bcd, 0);
    sweep("board_clear_with_lock");

    // score ceiling on a 2x4 board: 1249 four-line clears reach 9992
    ax = '{0, 0, 0, 0}; ay = '{0, 1, 2, 3};
    bx = '{1, 1, 1, 1}; by = '{0, 1, 2, 3};
    for (int k = 0; k < 1249; k++) begin
      s_do(1, ax, ay, 0);
      s_do(2, bx, by, 4);
    end
    xs = '{0, 1, 0, 1}; ys = '{2, 2, 3, 3};
    s_do(3, xs, ys, 2);
    chk("sat_9995", s_score, 16'h9995);
    s_do(3, xs, ys, 2);
    chk("sat_9998", s_score, 16'h9998);
    s_do(3, xs, ys, 2);
    chk("sat_9999", s_score, 16'h9999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
